// File: rtl/mdu_pkg.sv
// Shared types and widths for the MDU issue queue and its select logic.
package mdu_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int CONF_W = 4;

    localparam logic [CONF_W-1:0] MUL_CONF   = 4'd0;
    localparam logic [CONF_W-1:0] MULH_CONF  = 4'd1;
    localparam logic [CONF_W-1:0] MULHU_CONF = 4'd2;
    localparam logic [CONF_W-1:0] DIV_CONF   = 4'd3;
    localparam logic [CONF_W-1:0] DIVU_CONF  = 4'd4;
    localparam logic [CONF_W-1:0] MOD_CONF   = 4'd5;
    localparam logic [CONF_W-1:0] MODU_CONF  = 4'd6;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] pa;
        logic              pa_rdy;
        logic [PREG_W-1:0] pb;
        logic              pb_rdy;
        logic [PREG_W-1:0] pd;
        logic              regwr;
        logic [CONF_W-1:0] conf;
        logic [ROB_W-1:0]  tag_rob;
    } iq_entry_t;

endpackage

// File: rtl/mdu_iq_select.sv
// Find-first-set over the ready vector: lowest index (oldest entry) wins.
module mdu_iq_select #(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_issue_queue.sv
// Compacting issue queue for the MDU: wakeup, oldest-first select, one issue per cycle,
// and a credit counter bounding ops in flight to the MDU result buffer depth.
module mdu_issue_queue
    import mdu_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CREDITS     = 32,
    parameter int WAKE_N      = 4,
    parameter bit PROTO_CHECK = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_back,
    input  logic                     disp_valid,
    input  logic [PREG_W-1:0]        disp_Pa,
    input  logic [PREG_W-1:0]        disp_Pb,
    input  logic                     disp_Pa_rdy,
    input  logic                     disp_Pb_rdy,
    input  logic [PREG_W-1:0]        disp_Pd,
    input  logic                     disp_RegWr,
    input  logic [CONF_W-1:0]        disp_Conf,
    input  logic [ROB_W-1:0]         disp_tag_rob,
    output logic                     iq_full,
    input  logic [WAKE_N-1:0]        wake_valid,
    input  logic [WAKE_N*PREG_W-1:0] wake_Pd,
    input  logic                     mdu_done,
    output logic                     iss_ready,
    output logic [PREG_W-1:0]        iss_Pa,
    output logic [PREG_W-1:0]        iss_Pb,
    output logic [PREG_W-1:0]        iss_Pd,
    output logic                     iss_RegWr,
    output logic [CONF_W-1:0]        iss_Conf,
    output logic [ROB_W-1:0]         iss_tag_rob
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(CREDITS + 1);

    iq_entry_t        q     [DEPTH];
    iq_entry_t        q_nxt [DEPTH];
    iq_entry_t        disp_e;
    logic [CNT_W-1:0] count, count_nxt, wr_idx;
    logic [INF_W-1:0] inflight, inflight_nxt;
    logic [DEPTH-1:0] req, grant, shift;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any, disp_acc, credit_ok, done_ok;

    function automatic logic woken(input logic [PREG_W-1:0]        tag,
                                   input logic [WAKE_N-1:0]        vld,
                                   input logic [WAKE_N*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_N; p++) begin
            if (vld[p] && tags[p*PREG_W +: PREG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    assign iq_full   = (count == CNT_W'(DEPTH));
    assign disp_acc  = disp_valid && !iq_full;
    assign credit_ok = (inflight < INF_W'(CREDITS));
    assign done_ok   = mdu_done && (inflight != '0);

    // Select sees only registered rdy bits, so a wakeup needs one edge before it can issue.
    always_comb begin
        req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = q[i].valid && q[i].pa_rdy && q[i].pb_rdy && credit_ok;
        end
    end

    mdu_iq_select #(.DEPTH(DEPTH)) u_select (
        .req   (req),
        .grant (grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_comb begin
        shift    = '0;
        shift[0] = grant[0];
        for (int i = 1; i < DEPTH; i++) begin
            shift[i] = shift[i-1] | grant[i];
        end
    end

    always_comb begin
        disp_e.valid   = 1'b1;
        disp_e.pa      = disp_Pa;
        disp_e.pa_rdy  = disp_Pa_rdy || woken(disp_Pa, wake_valid, wake_Pd);
        disp_e.pb      = disp_Pb;
        disp_e.pb_rdy  = disp_Pb_rdy || woken(disp_Pb, wake_valid, wake_Pd);
        disp_e.pd      = disp_Pd;
        disp_e.regwr   = disp_RegWr;
        disp_e.conf    = disp_Conf;
        disp_e.tag_rob = disp_tag_rob;

        // Slot after compaction: the first free entry once this cycle's issue has shifted out.
        wr_idx = count - CNT_W'(sel_any);

        for (int i = 0; i < DEPTH-1; i++) begin
            q_nxt[i] = shift[i] ? q[i+1] : q[i];
        end
        q_nxt[DEPTH-1] = shift[DEPTH-1] ? '0 : q[DEPTH-1];

        for (int i = 0; i < DEPTH; i++) begin
            if (q_nxt[i].valid) begin
                if (woken(q_nxt[i].pa, wake_valid, wake_Pd)) q_nxt[i].pa_rdy = 1'b1;
                if (woken(q_nxt[i].pb, wake_valid, wake_Pd)) q_nxt[i].pb_rdy = 1'b1;
            end
            if (disp_acc && wr_idx == CNT_W'(i)) q_nxt[i] = disp_e;
        end
    end

    always_comb begin
        count_nxt    = count + CNT_W'(disp_acc) - CNT_W'(sel_any);
        inflight_nxt = inflight;
        if (sel_any && !done_ok)      inflight_nxt = inflight + INF_W'(1);
        else if (!sel_any && done_ok) inflight_nxt = inflight - INF_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count    <= '0;
            inflight <= '0;
        end else if (flush_back) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            count    <= count_nxt;
            inflight <= inflight_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_ready   <= 1'b0;
            iss_Pa      <= '0;
            iss_Pb      <= '0;
            iss_Pd      <= '0;
            iss_RegWr   <= 1'b0;
            iss_Conf    <= '0;
            iss_tag_rob <= '0;
        end else if (flush_back || !sel_any) begin
            iss_ready   <= 1'b0;
            iss_Pa      <= '0;
            iss_Pb      <= '0;
            iss_Pd      <= '0;
            iss_RegWr   <= 1'b0;
            iss_Conf    <= '0;
            iss_tag_rob <= '0;
        end else begin
            iss_ready   <= 1'b1;
            iss_Pa      <= q[sel_idx].pa;
            iss_Pb      <= q[sel_idx].pb;
            iss_Pd      <= q[sel_idx].pd;
            iss_RegWr   <= q[sel_idx].regwr;
            iss_Conf    <= q[sel_idx].conf;
            iss_tag_rob <= q[sel_idx].tag_rob;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (PROTO_CHECK && rst && !flush_back) begin
            assert (!(disp_valid && iq_full))
                else $error("mdu_issue_queue: dispatch while iq_full");
            assert (!(mdu_done && inflight == '0))
                else $error("mdu_issue_queue: mdu_done with nothing in flight");
        end
    end
`endif

endmodule
